// File: rtl/drac_pkg.sv
// Shared types for the IR stage: queue entry layout, issue FSM states and
// the serializing-instruction classifier used by the issue controller.
package drac_pkg;

  localparam int NUM_SCALAR_INSTR              = 2;
  localparam int INSTRUCTION_QUEUE_NUM_ENTRIES = 8;
  localparam int IQ_NUM_W                      = $clog2(INSTRUCTION_QUEUE_NUM_ENTRIES) + 1;
  localparam int DEF_PERF_CNT_W                = 32;

  typedef logic [4:0] reg_t;

  typedef enum logic [3:0] {
    INSTR_ALU,
    INSTR_LOAD,
    INSTR_STORE,
    INSTR_BRANCH,
    INSTR_FENCE,
    INSTR_FENCE_I,
    INSTR_CSR,
    INSTR_ECALL,
    INSTR_EBREAK,
    INSTR_XRET
  } instr_type_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    instr_type_t instr_type;
    reg_t        rd;
    reg_t        rs1;
    reg_t        rs2;
    logic        regfile_we;
    logic        use_rs1;
    logic        use_rs2;
  } instr_entry_t;

  typedef struct packed {
    instr_entry_t instr;
  } id_ir_stage_t;

  typedef enum logic [1:0] {
    RUN,
    WAIT_EMPTY,
    DRAIN
  } iq_issue_state_t;

  // Instructions that must see an empty pipeline and issue alone.
  function automatic logic is_serializing(input id_ir_stage_t e);
    logic ser;
    case (e.instr.instr_type)
      INSTR_FENCE, INSTR_FENCE_I, INSTR_CSR,
      INSTR_ECALL, INSTR_EBREAK, INSTR_XRET: ser = 1'b1;
      default:                               ser = 1'b0;
    endcase
    return ser;
  endfunction

endpackage

// File: rtl/iq_issue_ctrl_dep.sv
// Register dependency check between an older and a younger entry of the
// same issue group; purely combinational so it can be replicated for wider issue.
module iq_dep_check
  import drac_pkg::*;
(
  input  id_ir_stage_t older,
  input  id_ir_stage_t younger,
  output logic         raw,
  output logic         waw,
  output logic         split
);

  logic older_writes;
  logic unused_fields;

  assign older_writes = older.instr.regfile_we && (older.instr.rd != '0);

  assign raw = older_writes &&
               ((younger.instr.use_rs1 && (younger.instr.rs1 == older.instr.rd)) ||
                (younger.instr.use_rs2 && (younger.instr.rs2 == older.instr.rd)));

  assign waw = older_writes && younger.instr.regfile_we &&
               (younger.instr.rd == older.instr.rd);

  assign split = raw || waw;

  assign unused_fields = ^{older.instr.valid, older.instr.pc, older.instr.instr_type,
                           older.instr.rs1, older.instr.rs2, older.instr.use_rs1,
                           older.instr.use_rs2, younger.instr.valid, younger.instr.pc,
                           younger.instr.instr_type};

endmodule

// File: rtl/iq_issue_ctrl.sv
// Instruction-queue read side: picks 0/1/2 head entries per cycle, splits
// dependent pairs, serializes fence/CSR-class work and registers the result.
module iq_issue_ctrl
  import drac_pkg::*;
#(
  parameter int PERF_CNT_W = DEF_PERF_CNT_W
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  flush_i,
  input  id_ir_stage_t          instr_S_i [NUM_SCALAR_INSTR],
  input  logic [IQ_NUM_W-1:0]   iq_num_i,
  input  logic                  stall_i,
  input  logic                  pipeline_empty_i,
  output logic                  read_head_S_o [NUM_SCALAR_INSTR],
  output id_ir_stage_t          instr_S_o [NUM_SCALAR_INSTR],
  output logic                  valid_S_o [NUM_SCALAR_INSTR],
  output logic [PERF_CNT_W-1:0] cnt_dual_o,
  output logic [PERF_CNT_W-1:0] cnt_single_o,
  output logic [PERF_CNT_W-1:0] cnt_split_o
);

  iq_issue_state_t state_reg;

  logic       cand0, cand1, ser0, ser1, can_go;
  logic       split, unused_raw, unused_waw;
  logic [1:0] issue_vec;
  logic       split_blk;

  iq_dep_check u_dep (
    .older   (instr_S_i[0]),
    .younger (instr_S_i[1]),
    .raw     (unused_raw),
    .waw     (unused_waw),
    .split   (split)
  );

  // Gating with rstn_i keeps the pop strobes low while reset is held.
  assign cand0  = rstn_i && (iq_num_i >= IQ_NUM_W'(1)) && instr_S_i[0].instr.valid;
  assign cand1  = rstn_i && (iq_num_i >= IQ_NUM_W'(2)) && instr_S_i[1].instr.valid;
  assign ser0   = is_serializing(instr_S_i[0]);
  assign ser1   = is_serializing(instr_S_i[1]);
  assign can_go = !stall_i && !flush_i;

  always_comb begin
    issue_vec = '0;
    split_blk = 1'b0;
    case (state_reg)
      RUN: begin
        if (!ser0) begin
          issue_vec[0] = cand0 && can_go;
          issue_vec[1] = issue_vec[0] && cand1 && !split && !ser1;
          split_blk    = issue_vec[0] && cand1 && split && !ser1;
        end
      end
      WAIT_EMPTY: begin
        issue_vec[0] = cand0 && can_go && pipeline_empty_i &&
                       !valid_S_o[0] && !valid_S_o[1];
      end
      default: ;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NUM_SCALAR_INSTR; gi++) begin : g_pop
      assign read_head_S_o[gi] = issue_vec[gi];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg <= RUN;
    end else if (flush_i) begin
      state_reg <= RUN;
    end else begin
      case (state_reg)
        RUN:        if (cand0 && ser0) state_reg <= WAIT_EMPTY;
        WAIT_EMPTY: if (issue_vec[0]) state_reg <= DRAIN;
        DRAIN:      if (!valid_S_o[0] && pipeline_empty_i) state_reg <= RUN;
        default:    state_reg <= RUN;
      endcase
    end
  end

  // Payload follows the queue head whenever downstream accepts.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_SCALAR_INSTR; i++) begin
        instr_S_o[i] <= '0;
        valid_S_o[i] <= 1'b0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < NUM_SCALAR_INSTR; i++) begin
        valid_S_o[i] <= 1'b0;
      end
    end else if (!stall_i) begin
      for (int i = 0; i < NUM_SCALAR_INSTR; i++) begin
        instr_S_o[i] <= instr_S_i[i];
        valid_S_o[i] <= issue_vec[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_dual_o   <= '0;
      cnt_single_o <= '0;
      cnt_split_o  <= '0;
    end else begin
      if (issue_vec[1] && (cnt_dual_o != '1))
        cnt_dual_o <= cnt_dual_o + 1'b1;
      if (issue_vec[0] && !issue_vec[1] && (cnt_single_o != '1))
        cnt_single_o <= cnt_single_o + 1'b1;
      if (split_blk && (cnt_split_o != '1))
        cnt_split_o <= cnt_split_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_iq_issue_ctrl.sv
// Directed bench for iq_issue_ctrl: expected outputs are queued when a cycle
// is driven and popped after the clock edge that should produce them.
module tb_iq_issue_ctrl;
  import drac_pkg::*;

  logic                clk_i = 1'b0;
  logic                rstn_i, flush_i, stall_i, pipeline_empty_i;
  logic [IQ_NUM_W-1:0] iq_num_i;
  id_ir_stage_t        instr_in  [NUM_SCALAR_INSTR];
  id_ir_stage_t        instr_out [NUM_SCALAR_INSTR];
  logic                rh        [NUM_SCALAR_INSTR];
  logic                vout      [NUM_SCALAR_INSTR];
  logic [31:0]         cnt_dual, cnt_single, cnt_split;

  always #5 clk_i = ~clk_i;

  iq_issue_ctrl #(.PERF_CNT_W(32)) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .flush_i          (flush_i),
    .instr_S_i        (instr_in),
    .iq_num_i         (iq_num_i),
    .stall_i          (stall_i),
    .pipeline_empty_i (pipeline_empty_i),
    .read_head_S_o    (rh),
    .instr_S_o        (instr_out),
    .valid_S_o        (vout),
    .cnt_dual_o       (cnt_dual),
    .cnt_single_o     (cnt_single),
    .cnt_split_o      (cnt_split)
  );

  typedef struct {
    logic [1:0]   v;
    id_ir_stage_t i0;
    id_ir_stage_t i1;
    logic         chk_i;
  } exp_t;

  exp_t         sb[$];
  int           n_chk  = 0;
  int           n_fail = 0;
  logic [1:0]   held_v;
  id_ir_stage_t held0, held1;
  logic         held_ok;
  int           exp_dual, exp_single, exp_split;

  function automatic id_ir_stage_t mk(input logic v, input instr_type_t t,
                                      input int rd, input int rs1, input int rs2);
    id_ir_stage_t e;
    e = '0;
    e.instr.valid      = v;
    e.instr.pc         = $urandom;
    e.instr.instr_type = t;
    e.instr.rd         = reg_t'(rd);
    e.instr.rs1        = reg_t'(rs1);
    e.instr.rs2        = reg_t'(rs2);
    e.instr.regfile_we = 1'b1;
    e.instr.use_rs1    = 1'b1;
    e.instr.use_rs2    = (t == INSTR_ALU);
    return e;
  endfunction

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input id_ir_stage_t a, input id_ir_stage_t b, input int n);
    instr_in[0] = a;
    instr_in[1] = b;
    iq_num_i    = IQ_NUM_W'(n);
  endtask

  task automatic chk_cnt(input string tag);
    chk(64'(cnt_dual),   64'(exp_dual),   {tag, ".cnt_dual"});
    chk(64'(cnt_single), 64'(exp_single), {tag, ".cnt_single"});
    chk(64'(cnt_split),  64'(exp_split),  {tag, ".cnt_split"});
  endtask

  // One clock cycle: check pop strobes, queue expectation, clock, compare.
  task automatic step(input logic [1:0] exp_rh, input logic split_inc, input string tag);
    exp_t e;
    #1;
    chk(64'({rh[1], rh[0]}), 64'(exp_rh), {tag, ".read_head"});
    e.v = held_v; e.i0 = held0; e.i1 = held1; e.chk_i = held_ok;
    if (flush_i) begin
      e.v = 2'b00; e.chk_i = 1'b0;
    end else if (!stall_i) begin
      e.v = exp_rh; e.i0 = instr_in[0]; e.i1 = instr_in[1]; e.chk_i = 1'b1;
    end
    sb.push_back(e);
    if (exp_rh == 2'b11) exp_dual++;
    else if (exp_rh == 2'b01) exp_single++;
    if (split_inc) exp_split++;
    @(posedge clk_i); #1;
    e = sb.pop_front();
    chk(64'({vout[1], vout[0]}), 64'(e.v), {tag, ".valid"});
    if (e.chk_i) begin
      chk(64'(instr_out[0]), 64'(e.i0), {tag, ".instr0"});
      chk(64'(instr_out[1]), 64'(e.i1), {tag, ".instr1"});
    end
    held_v = e.v; held0 = e.i0; held1 = e.i1; held_ok = e.chk_i;
    $display("step %-12s read_head=%b valid=%b", tag, exp_rh, e.v);
  endtask

  task automatic model_reset();
    held_v = 2'b00; held0 = '0; held1 = '0; held_ok = 1'b1;
    exp_dual = 0; exp_single = 0; exp_split = 0;
  endtask

  initial begin
    id_ir_stage_t a, b, c, d, e2, f, g, h, s, z;
    a  = mk(1, INSTR_ALU, 1, 2, 3);
    b  = mk(1, INSTR_ALU, 4, 5, 6);
    c  = mk(1, INSTR_ALU, 7, 1, 2);
    d  = mk(1, INSTR_ALU, 9, 7, 3);
    e2 = mk(1, INSTR_ALU, 8, 1, 2);
    f  = mk(1, INSTR_ALU, 8, 3, 4);
    g  = mk(1, INSTR_ALU, 0, 1, 2);
    h  = mk(1, INSTR_ALU, 0, 0, 0);
    s  = mk(1, INSTR_CSR, 3, 1, 0);
    z  = mk(0, INSTR_ALU, 0, 0, 0);

    rstn_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0; pipeline_empty_i = 1'b1;
    set_in(a, b, 4);
    model_reset();
    #3;
    chk(64'({rh[1], rh[0]}), 64'(0), "reset.read_head");
    @(posedge clk_i); #1;
    chk(64'({vout[1], vout[0]}), 64'(0), "reset.valid");
    chk(64'(instr_out[0]), 64'(0), "reset.instr0");
    chk(64'(instr_out[1]), 64'(0), "reset.instr1");
    chk_cnt("reset");
    rstn_i = 1'b1;

    set_in(a, b, 4);  step(2'b11, 1'b0, "dual");
    chk_cnt("dual");

    set_in(c, d, 4);  step(2'b01, 1'b1, "raw0");
    set_in(d, z, 1);  step(2'b01, 1'b0, "raw1");
    chk_cnt("raw");

    set_in(e2, f, 2); step(2'b01, 1'b1, "waw0");
    set_in(f, b, 1);  step(2'b01, 1'b0, "waw1");
    set_in(g, h, 2);  step(2'b11, 1'b0, "x0_pair");
    set_in(a, b, 1);  step(2'b01, 1'b0, "iq1_garbage");
    set_in(a, b, 0);  step(2'b00, 1'b0, "iq0");
    set_in(a, s, 2);  step(2'b01, 1'b0, "ser_slot1");
    chk_cnt("hazards");

    set_in(a, b, 2);  step(2'b11, 1'b0, "pre_stall");
    stall_i = 1'b1;
    set_in(c, d, 2);  step(2'b00, 1'b0, "stall0");
                      step(2'b00, 1'b0, "stall1");
    stall_i = 1'b0;
    set_in(z, z, 0);  step(2'b00, 1'b0, "idle");

    pipeline_empty_i = 1'b0;
    set_in(s, a, 2);  step(2'b00, 1'b0, "csr_run");
                      step(2'b00, 1'b0, "csr_wait1");
                      step(2'b00, 1'b0, "csr_wait2");
    pipeline_empty_i = 1'b1;
                      step(2'b01, 1'b0, "csr_issue");
    pipeline_empty_i = 1'b0;
    set_in(a, b, 2);  step(2'b00, 1'b0, "drain0");
                      step(2'b00, 1'b0, "drain1");
    pipeline_empty_i = 1'b1;
                      step(2'b00, 1'b0, "drain_exit");
                      step(2'b11, 1'b0, "post_drain");
    chk_cnt("serialize");

    pipeline_empty_i = 1'b0;
    set_in(a, b, 2);  step(2'b11, 1'b0, "pre_flush");
    stall_i = 1'b1;
    set_in(s, a, 2);  step(2'b00, 1'b0, "stall_csr");
    flush_i = 1'b1;   step(2'b00, 1'b0, "flush_stall");
    flush_i = 1'b0; stall_i = 1'b0;
    set_in(a, b, 2);  step(2'b11, 1'b0, "post_flush");
    flush_i = 1'b1;   step(2'b00, 1'b0, "flush_only");
    flush_i = 1'b0;
    chk_cnt("flush");

    set_in(s, a, 2);  step(2'b00, 1'b0, "rst_ser");
    rstn_i = 1'b0;
    #1;
    model_reset();
    chk(64'({vout[1], vout[0]}), 64'(0), "async_rst.valid");
    chk(64'(instr_out[0]), 64'(0), "async_rst.instr0");
    chk_cnt("async_rst");
    rstn_i = 1'b1;
    #1;
    set_in(a, z, 1);  step(2'b01, 1'b0, "post_rst");
    chk_cnt("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/iq_issue_ctrl.md
# iq_issue_ctrl

Read-side controller for the IR-stage instruction queue. It examines the two queue head entries every cycle and decides how many to pop: zero, one or two. Popped entries go into a registered dual-slot output toward register read/rename. It splits dependent pairs, serializes fence/CSR-class instructions behind a pipeline drain, and honours downstream stall and flush.

## Interface
- NUM_SCALAR_INSTR, 2 (from drac_pkg, fixed): issue width; slot 0 is always older.
- PERF_CNT_W, 32: width of the saturating performance counters.
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  kill output slots, pop nothing this cycle, FSM to RUN.
- instr_S_i[NUM_SCALAR_INSTR]  in  id_ir_stage_t  queue head entry and head+1 entry.
- iq_num_i  in  $clog2(INSTRUCTION_QUEUE_NUM_ENTRIES)+1  number of occupied queue entries.
- stall_i  in  1  downstream cannot accept; output register holds.
- pipeline_empty_i  in  1  no instruction in flight past this stage.
- read_head_S_o[NUM_SCALAR_INSTR]  out  1 each  pop strobes to the queue.
- instr_S_o[NUM_SCALAR_INSTR]  out  id_ir_stage_t  registered issued entries.
- valid_S_o[NUM_SCALAR_INSTR]  out  1 each  slot valid.
- cnt_dual_o, cnt_single_o, cnt_split_o  out  PERF_CNT_W  saturating issue counters.

## Operation
- Candidate logic:
  - cand0 = (iq_num_i >= 1) and instr_S_i[0].instr.valid.
  - cand1 = (iq_num_i >= 2) and instr_S_i[1].instr.valid.
- Hazard:
  - RAW: slot0 writes rd != x0 and slot1 reads that register through rs1 or rs2.
  - WAW: both slots write the same rd != x0.
  - Either hazard is a split.
- Serializing (is_serializing(): fence, fence.i, CSR, ecall/ebreak, xret) may only occupy slot 0 alone.
- FSM states: RUN, WAIT_EMPTY, DRAIN.
  - RUN:
    - issue0 = cand0 and not stall_i and not flush_i and not serializing(slot0).
    - issue1 = issue0 and cand1 and no split and not serializing(slot1).
    - If slot0 is serializing, issue nothing and go to WAIT_EMPTY.
  - WAIT_EMPTY: when pipeline_empty_i, valid_S_o both 0 and not stall_i, issue slot0 alone (issue1 = 0) and go to DRAIN.
  - DRAIN:
    - No issue.
    - Return to RUN when valid_S_o[0] = 0 and pipeline_empty_i.
- Pop strobes:
  - read_head_S_o[i] = issue_i.
  - read_head_S_o[1] implies read_head_S_o[0]; a pop of slot 1 without slot 0 never occurs.
- Output register, when not stall_i:
  - instr_S_o <= instr_S_i (pass-through).
  - valid_S_o <= {issue1, issue0}.
  - When stall_i, hold and pop nothing.
- Flush takes priority over stall, and clears valid_S_o and the FSM; instr_S_o payload is don't-care.
- Counters increment at the clock edge on an issue cycle, saturating at all-ones:
  - cnt_dual on issue1.
  - cnt_single on issue0 without issue1.
  - cnt_split when cand1 was blocked only by a hazard.
- Reset values: valid_S_o = 0, instr_S_o = 0, read_head_S_o = 0 (combinational, since issue is gated), state RUN, counters 0.

## Timing
- Pops are combinational in the same cycle the head is presented; the queue advances at the next edge.
- The issued entry appears on instr_S_o/valid_S_o one cycle after its pop.
- Peak throughput is 2 per cycle with no bubbles across a queue wrap-around, because the queue handles indexing.
- Serialization cost, minimum: 1 cycle to enter WAIT_EMPTY, 1 issue cycle, plus drain until pipeline_empty_i, then 1 cycle back to RUN.
- iq_num_i = 1: only slot 0 is considered, whatever instr_S_i[1] holds.
- Stall and flush in the same cycle: flush wins, the slots are cleared and nothing is popped.
- Reset asserted mid-serialization returns to RUN immediately, asynchronously.

## Structure
- drac_pkg gains:
  - iq_issue_state_t enum {RUN, WAIT_EMPTY, DRAIN}.
  - function is_serializing(id_ir_stage_t).
  - PERF_CNT_W default constant.
- Sub-module iq_dep_check: purely combinational; takes two id_ir_stage_t and returns raw, waw and split. It is reused by a future 4-wide issue.
- Top level holds the FSM, the output register and the counters.

## Test plan
- iq_num_i = 4, independent ALU pair (x1 <= x2+x3, x4 <= x5+x6), no stall -> read_head = {1,1}; next cycle valid_S_o = {1,1}; cnt_dual = 1.
- Pair where slot1 reads x1 written by slot0 -> cycle 0 pops only slot 0; cycle 1 pops slot 1 alone; cnt_split = 1, cnt_single = 2.
- Slot0 is a CSR write with pipeline_empty_i low for 3 cycles -> no pops for 3 cycles, then a single pop; DRAIN until pipeline_empty_i; the next instruction issues 1 cycle after.
- stall_i high for 2 cycles with a valid output -> instr_S_o and valid_S_o are unchanged; read_head = 0 throughout.
- flush_i together with stall_i while in WAIT_EMPTY -> valid_S_o = 0 and state RUN next cycle; no pop.
- iq_num_i = 1 with a garbage valid bit in instr_S_i[1] -> only slot 0 pops; rd = x0 pairs never count as a hazard.
